alu_req_initiator: RTL and testbench
====================================

Name: alu_req_initiator

Overview:
- Initiator side of the versioned 4-bit ALU interface. Accepts operand pairs on a valid/ready request channel and drives them onto the ALU operand lines.
- Waits a fixed ALU latency, then samples the version-selected result line (out1 for version 1, out2 otherwise).
- Returns the sample, tagged, through a small response FIFO with backpressure. Serves as the stimulus/collection end for ALU responder instances in cosim benches.

Parameters:
- VERSION, 1, selects the result line: 1 = alu_out1, any other value = alu_out2.
- LATENCY, 2, ALU cycles between operand drive and result sample; legal range 1..15.
- DEPTH, 4, response FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready at the clock edge.
- req_a  input  4  operand a.
- req_b  input  4  operand b.
- alu_a  output  4  registered operand a to the ALU.
- alu_b  output  4  registered operand b to the ALU.
- alu_out1  input  4  ALU result line, version 1.
- alu_out2  input  4  ALU result line, version 2.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  pop when rsp_valid && rsp_ready at the clock edge.
- rsp_data  output  4  FIFO head result.
- rsp_tag  output  4  FIFO head request tag.
- busy  output  1  high while in DRIVE.

Behaviour:
- Reset values while rst is high: req_ready=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0. FIFO empty, tag counter=0, state=IDLE.
- States:
  - IDLE: req_ready = (fifo_count + 0) < DEPTH. On accept: alu_a<=req_a, alu_b<=req_b, cur_tag<=tag_cnt, tag_cnt<=tag_cnt+1 (4-bit, wraps 15->0), wait_cnt<=LATENCY-1, go to DRIVE.
  - DRIVE: busy=1, req_ready=0, alu_a/alu_b held. If wait_cnt!=0, decrement. If wait_cnt==0, at that edge push {sample, cur_tag} into the FIFO and go to IDLE. Sample is alu_out1 when VERSION==1, else alu_out2.
- Latency: accept at edge E0, push at edge E(LATENCY). rsp_valid rises after E(LATENCY) if the FIFO was empty. Next accept is possible no earlier than E(LATENCY+1). Throughput is one request per LATENCY+1 cycles.
- alu_a/alu_b retain their last value in IDLE; they are not cleared.
- FIFO slot reservation: a request is accepted only when count<DEPTH. Only one request is ever in flight, so a push never finds the FIFO full.
- Simultaneous push and pop: count unchanged; pointers advance independently with modulo-DEPTH wrap.
- Pop from an empty FIFO is impossible (rsp_valid=0).
- rsp_data/rsp_tag are the FIFO head, stable while rsp_valid && !rsp_ready.
- Reset mid-operation (any state): in-flight request dropped, FIFO flushed, tag counter back to 0. Outputs take reset values immediately (asynchronous).
- After rst deasserts, req_ready=1 in the first IDLE cycle.

Optional Feature:
- Macro: ALU_REQ_CHECK_EN
- Defined: adds output chk_err (1 bit, sticky, reset 0).
  - At each push, the expected value is alu_a for VERSION==1, alu_b otherwise (the responder contract).
  - If sample != expected, chk_err is set at that edge; it clears only on rst.
  - Also adds output chk_count (8-bit, saturating at 255): counts pushes whose sample matched.
- Undefined: no chk_err/chk_count ports and no checking logic; all other behaviour identical.

Test Plan:
- VERSION=1, LATENCY=2, ALU model out1=a: req a=3, b=9 accepted at E0 -> push at E2, rsp_valid from after E2 with rsp_data=3, rsp_tag=0; req_ready low E0..E2.
- VERSION=2, LATENCY=1, ALU model out2=b: req a=3, b=9 -> rsp_data=9, rsp_tag=0; back-to-back req_valid=1 gives accepts every 2 cycles, tags 0,1,2.
- DEPTH=4, rsp_ready=0: four requests complete -> FIFO holds tags 0..3 and req_ready stays 0 with a fifth pending. Pulse rsp_ready one cycle -> tag 0 popped, fifth accepted next IDLE cycle, later returns tag 4.
- 17 sequential requests with rsp_ready=1 -> rsp_tag sequence 0..15 then 0; data order matches request order.
- Assert rst during DRIVE with one FIFO entry pending -> rsp_valid=0 and busy=0 immediately. After release, the next request returns rsp_tag=0.
- ALU_REQ_CHECK_EN, VERSION=1, ALU model out1=a^1: req a=4 -> rsp_data=5, chk_err=1 after the push edge and stays 1; a correct ALU model over 10 requests -> chk_err=0, chk_count=10.

Source files
------------

// File: rtl/alu_req_initiator.sv
// Initiator for the versioned 4-bit ALU: drives operands, samples the result after LATENCY cycles
// and returns tagged results through a response FIFO. Optional checker: define ALU_REQ_CHECK_EN.
module alu_req_initiator #(
    parameter int VERSION = 1,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out1,
    input  logic [3:0] alu_out2,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [3:0] rsp_tag,
    output logic       busy
`ifdef ALU_REQ_CHECK_EN
    ,
    output logic       chk_err,
    output logic [7:0] chk_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0]    WAIT_INIT  = 4'(LATENCY - 1);

    typedef enum logic {IDLE, DRIVE} state_t;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] tag;
    } entry_t;

    state_t          state, state_nxt;
    logic            accept, push, pop;
    logic [3:0]      tag_cnt, cur_tag, wait_cnt, sample;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    entry_t          mem [DEPTH];
    entry_t          head;

    assign accept    = req_valid && req_ready;
    assign push      = busy && (wait_cnt == 4'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign sample    = (VERSION == 1) ? alu_out1 : alu_out2;
    assign rsp_valid = (count != '0);

    // NOTE: sequential state is written with <= only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   if (wait_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rst so it reads 0 while reset is held, not just after it.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    req_ready = !rst && (count < FULL_COUNT);
            DRIVE:   busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            cur_tag  <= 4'd0;
            tag_cnt  <= 4'd0;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            cur_tag  <= tag_cnt;
            tag_cnt  <= tag_cnt + 4'd1;
            wait_cnt <= WAIT_INIT;
        end else if (busy && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // A push can never meet a full FIFO: the slot was reserved when the request was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: sample, tag: cur_tag};
    end

    assign head     = rsp_valid ? mem[rd_ptr] : '0;
    assign rsp_data = head.data;
    assign rsp_tag  = head.tag;

`ifdef ALU_REQ_CHECK_EN
    logic [3:0] expected;

    // The responder contract: version 1 echoes a on out1, other versions echo b on out2.
    assign expected = (VERSION == 1) ? alu_a : alu_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err   <= 1'b0;
            chk_count <= 8'd0;
        end else if (push) begin
            if (sample != expected)      chk_err   <= 1'b1;
            else if (chk_count != 8'hFF) chk_count <= chk_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_initiator.sv
// Randomized bench for alu_req_initiator: two instances (V1/L2/D4 and V2/L1/D2) checked each cycle
// against a transaction-level model built from queues.
module tb_alu_req_initiator;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] tag;
    } txn_t;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] tag;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [1:0][3:0] req_a, req_b, alu_a, alu_b, alu_out1, alu_out2, rsp_data, rsp_tag, flip, flip_sel;
`ifdef ALU_REQ_CHECK_EN
    logic [1:0]      chk_err;
    logic [1:0][7:0] chk_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    rsp_t       mq [2][$];
    txn_t       m_cur [2];
    bit         m_busy [2];
    int         push_edge [2];
    logic [3:0] m_tag [2];
    bit         m_err [2];
    int         m_cnt [2];
    int         edge_n = 0;

    always #5 clk = ~clk;

    // ALU models: the selected line echoes the operand (optionally corrupted), the other line differs.
    assign alu_out1[0] = alu_a[0] ^ flip[0];
    assign alu_out2[0] = ~alu_b[0];
    assign alu_out1[1] = ~alu_a[1];
    assign alu_out2[1] = alu_b[1] ^ flip[1];

    alu_req_initiator #(.VERSION(1), .LATENCY(2), .DEPTH(4)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_out1(alu_out1[0]), .alu_out2(alu_out2[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_tag(rsp_tag[0]),
        .busy(busy[0])
`ifdef ALU_REQ_CHECK_EN
        , .chk_err(chk_err[0]), .chk_count(chk_count[0])
`endif
    );

    alu_req_initiator #(.VERSION(2), .LATENCY(1), .DEPTH(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_out1(alu_out1[1]), .alu_out2(alu_out2[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_tag(rsp_tag[1]),
        .busy(busy[1])
`ifdef ALU_REQ_CHECK_EN
        , .chk_err(chk_err[1]), .chk_count(chk_count[1])
`endif
    );

    function automatic int ver(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int lat(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int dep(input int i); return (i == 0) ? 4 : 2; endfunction

    task automatic check(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", tag, i, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_busy[i] = 1'b0;
            m_tag[i]  = 4'd0;
            m_err[i]  = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    function automatic bit model_ready(input int i);
        return !m_busy[i] && (mq[i].size() < dep(i));
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check("req_ready", i, 8'(req_ready[i]), 8'(model_ready(i)));
            check("busy", i, 8'(busy[i]), 8'(m_busy[i]));
            check("rsp_valid", i, 8'(rsp_valid[i]), 8'(mq[i].size() != 0));
            if (mq[i].size() != 0) begin
                check("rsp_data", i, 8'(rsp_data[i]), 8'(mq[i][0].data));
                check("rsp_tag", i, 8'(rsp_tag[i]), 8'(mq[i][0].tag));
            end
            if (m_busy[i]) begin
                check("alu_a", i, 8'(alu_a[i]), 8'(m_cur[i].a));
                check("alu_b", i, 8'(alu_b[i]), 8'(m_cur[i].b));
            end
`ifdef ALU_REQ_CHECK_EN
            check("chk_err", i, 8'(chk_err[i]), 8'(m_err[i]));
            check("chk_count", i, chk_count[i], 8'(m_cnt[i]));
`endif
        end
    endtask

    // One clock: check at negedge, drive inputs, then advance the model across the coming posedge.
    task automatic step(input int p_req, input int p_rsp, input bit use_ab, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        bit acc, pop, psh;
        @(negedge clk);
        check_outputs();
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            flip[i]      = flip_sel[i];
            req_valid[i] = ($urandom_range(0, 99) < p_req);
            req_a[i]     = use_ab ? a : 4'($urandom);
            req_b[i]     = use_ab ? b : 4'($urandom);
            rsp_ready[i] = ($urandom_range(0, 99) < p_rsp);
            acc = req_valid[i] && model_ready(i);
            pop = (mq[i].size() != 0) && rsp_ready[i];
            psh = m_busy[i] && (push_edge[i] == edge_n);
            if (pop) void'(mq[i].pop_front());
            if (psh) begin
                d = (ver(i) == 1) ? (m_cur[i].a ^ flip[i]) : (m_cur[i].b ^ flip[i]);
                mq[i].push_back('{data: d, tag: m_cur[i].tag});
                if (flip[i] != 4'd0)  m_err[i] = 1'b1;
                else if (m_cnt[i] < 255) m_cnt[i]++;
                m_busy[i] = 1'b0;
            end
            if (acc) begin
                m_cur[i]     = '{a: req_a[i], b: req_b[i], tag: m_tag[i]};
                m_tag[i]     = m_tag[i] + 4'd1;
                m_busy[i]    = 1'b1;
                push_edge[i] = edge_n + lat(i);
            end
        end
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", i, 8'(req_ready[i]), 8'd0);
            check("rst_busy", i, 8'(busy[i]), 8'd0);
            check("rst_rsp_valid", i, 8'(rsp_valid[i]), 8'd0);
            check("rst_rsp_data", i, 8'(rsp_data[i]), 8'd0);
            check("rst_rsp_tag", i, 8'(rsp_tag[i]), 8'd0);
            check("rst_alu_a", i, 8'(alu_a[i]), 8'd0);
            check("rst_alu_b", i, 8'(alu_b[i]), 8'd0);
`ifdef ALU_REQ_CHECK_EN
            check("rst_chk_err", i, 8'(chk_err[i]), 8'd0);
            check("rst_chk_count", i, chk_count[i], 8'd0);
`endif
        end
    endtask

    // Release reset at a negedge with idle inputs so the first edge after release is a no-op.
    task automatic release_reset();
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
        flip = '0; flip_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        release_reset();

        // Single directed request, then drain
        step(100, 100, 1'b1, 4'd3, 4'd9);
        repeat (6) step(0, 100, 1'b0, 4'd0, 4'd0);

        // Back-to-back requests with the response side always ready
        repeat (24) step(100, 100, 1'b0, 4'd0, 4'd0);

        // Fill the FIFOs, pulse rsp_ready once, then keep them blocked
        repeat (30) step(100, 0, 1'b0, 4'd0, 4'd0);
        step(100, 100, 1'b0, 4'd0, 4'd0);
        repeat (10) step(100, 0, 1'b0, 4'd0, 4'd0);
        repeat (20) step(0, 100, 1'b0, 4'd0, 4'd0);

        // Random traffic, occasionally with a faulty ALU
        for (int blk = 0; blk < 24; blk++) begin
            for (int i = 0; i < 2; i++)
                flip_sel[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            repeat (50) step($urandom_range(30, 100), $urandom_range(10, 100), 1'b0, 4'd0, 4'd0);
        end

        // Reset while instance 0 is in DRIVE with a response pending
        flip_sel = '0;
        repeat (12) step(0, 100, 1'b0, 4'd0, 4'd0);
        for (int n = 0; n < 20 && !(m_busy[0] && mq[0].size() != 0); n++)
            step(100, 0, 1'b0, 4'd0, 4'd0);
        @(posedge clk);
        #2;
        check("pre_rst_busy", 0, 8'(busy[0]), 8'd1);
        check("pre_rst_rsp_valid", 0, 8'(rsp_valid[0]), 8'd1);
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        release_reset();

        // After reset the tag restarts at 0; a healthy ALU keeps the checker clean
        repeat (60) step(100, 100, 1'b0, 4'd0, 4'd0);
        repeat (8) step(0, 100, 1'b0, 4'd0, 4'd0);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
